// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte strobes plus an MMIO window (cycle counter,
// TOHOST halt, fault capture). Define DMEM_ACCESS_STATS_EN to add RAM access counters.
module data_mem_responder #(
    parameter int unsigned DEPTH_LOG2 = 14,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_read,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        done,
    output logic        fault
);

    localparam int unsigned Words = 1 << DEPTH_LOG2;

    // MMIO word offsets
    localparam logic [3:0] RegCycleLo   = 4'h0;
    localparam logic [3:0] RegCycleHi   = 4'h1;
    localparam logic [3:0] RegTohost    = 4'h2;
    localparam logic [3:0] RegFaultAddr = 4'h3;
`ifdef DMEM_ACCESS_STATS_EN
    localparam logic [3:0] RegReadCnt   = 4'h4;
    localparam logic [3:0] RegWriteCnt  = 4'h5;
`endif

    logic [31:0] ram [Words];

    logic [63:0] cycle_q;
    logic [31:0] hi_shadow_q;
    logic [31:0] tohost_q;
    logic [31:0] tohost_d;
    logic [31:0] fault_addr_q;
    logic        done_q;
    logic        fault_q;
`ifdef DMEM_ACCESS_STATS_EN
    logic [31:0] read_cnt_q;
    logic [31:0] write_cnt_q;
`endif

    logic                  ram_hit;
    logic                  mmio_hit;
    logic                  miss;
    logic                  any_write;
    logic                  access;
    logic [31:0]           mmio_off;
    logic [3:0]            reg_sel;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic                  tohost_we;
    logic                  lo_read;
    logic [31:0]           mmio_rdata;

    // Unsigned wrap makes (addr - base) < 64 an exact window test.
    assign mmio_off  = data_addr - MMIO_BASE;
    assign ram_hit   = (data_addr[31:DEPTH_LOG2+2] == '0);
    assign mmio_hit  = !ram_hit && (mmio_off[31:6] == '0);
    assign miss      = !ram_hit && !mmio_hit;
    assign reg_sel   = mmio_off[5:2];
    assign ram_idx   = data_addr[DEPTH_LOG2+1:2];
    assign any_write = |data_write;
    assign access    = data_read | any_write;
    assign tohost_we = mmio_hit && any_write && (reg_sel == RegTohost);
    assign lo_read   = mmio_hit && data_read && (reg_sel == RegCycleLo);

    always_comb begin
        tohost_d = tohost_q;
        for (int i = 0; i < 4; i++) begin
            if (data_write[i]) begin
                tohost_d[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    always_comb begin
        mmio_rdata = '0;
        case (reg_sel)
            RegCycleLo:   mmio_rdata = cycle_q[31:0];
            RegCycleHi:   mmio_rdata = hi_shadow_q;
            RegTohost:    mmio_rdata = tohost_q;
            RegFaultAddr: mmio_rdata = fault_addr_q;
`ifdef DMEM_ACCESS_STATS_EN
            RegReadCnt:   mmio_rdata = read_cnt_q;
            RegWriteCnt:  mmio_rdata = write_cnt_q;
`endif
            default:      mmio_rdata = '0;
        endcase
    end

    always_comb begin
        data_out = '0;
        if (data_read) begin
            if (ram_hit) begin
                data_out = ram[ram_idx];
            end else if (mmio_hit) begin
                data_out = mmio_rdata;
            end
        end
    end

    // RAM is intentionally not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (data_write[i]) begin
                    ram[ram_idx][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q      <= '0;
            hi_shadow_q  <= '0;
            tohost_q     <= '0;
            fault_addr_q <= '0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (lo_read) begin
                hi_shadow_q <= cycle_q[63:32];
            end
            if (tohost_we) begin
                tohost_q <= tohost_d;
                if (tohost_d != '0) begin
                    done_q <= 1'b1;
                end
            end
            if (access && miss) begin
                fault_q <= 1'b1;
                if (!fault_q) begin
                    fault_addr_q <= data_addr;
                end
            end
        end
    end

`ifdef DMEM_ACCESS_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            read_cnt_q  <= '0;
            write_cnt_q <= '0;
        end else begin
            if (data_read && ram_hit) begin
                read_cnt_q <= read_cnt_q + 32'd1;
            end
            if (any_write && ram_hit) begin
                write_cnt_q <= write_cnt_q + 32'd1;
            end
        end
    end
`endif

    assign done  = done_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (default parameters).
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        data_read;
    logic [3:0]  data_write;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        done;
    logic        fault;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] Base = 32'hFFFF_0000;

    data_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .data_read  (data_read),
        .data_write (data_write),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .done       (done),
        .fault      (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus just after the falling edge.
    task automatic drive(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                         input logic [31:0] din);
        @(negedge clk);
        data_read  = rd;
        data_write = wr;
        data_addr  = addr;
        data_in    = din;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst        = 1'b1;
        data_read  = 1'b0;
        data_write = 4'h0;
        data_addr  = '0;
        data_in    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset data_out", data_out, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset fault", {31'h0, fault}, 32'h0);
        data_read = 1'b1;
        data_addr = Base;
        #1;
        check("first cycle CYCLE_LO", data_out, 32'h0);

        drive(1'b1, 4'h0, Base + 32'h0C, 32'h0);
        check("reset FAULT_ADDR", data_out, 32'h0);
        drive(1'b1, 4'h0, Base + 32'h04, 32'h0);
        check("reset CYCLE_HI", data_out, 32'h0);

        // Byte-strobe store
        idle();
        dut.ram[16] = 32'h1122_3344;
        drive(1'b0, 4'b0110, 32'h40, 32'hAABB_CCDD);
        drive(1'b1, 4'h0, 32'h40, 32'h0);
        check("strobe 0110", data_out, 32'h11BB_CC44);
        drive(1'b0, 4'hF, 32'h40, 32'hDEAD_BEEF);
        drive(1'b1, 4'h0, 32'h40, 32'h0);
        check("strobe 1111", data_out, 32'hDEAD_BEEF);
        drive(1'b0, 4'h0, 32'h40, 32'h0);
        check("no read data_out 0", data_out, 32'h0);

        // Same-cycle read and write
        idle();
        dut.ram[64] = 32'h5;
        drive(1'b1, 4'hF, 32'h100, 32'h9);
        check("rmw old data", data_out, 32'h5);
        drive(1'b1, 4'h0, 32'h100, 32'h0);
        check("rmw new data", data_out, 32'h9);

        // Cycle counter snapshot across the 32-bit boundary
        @(negedge clk);
        dut.cycle_q = 64'h0000_0000_FFFF_FFFE;
        data_read  = 1'b1;
        data_write = 4'h0;
        data_addr  = Base;
        #1;
        check("CYCLE_LO pre-wrap", data_out, 32'hFFFF_FFFE);
        idle();
        drive(1'b1, 4'h0, Base + 32'h04, 32'h0);
        check("CYCLE_HI shadow", data_out, 32'h0);
        drive(1'b1, 4'h0, Base, 32'h0);
        check("CYCLE_LO post-wrap", data_out, 32'h1);
        drive(1'b1, 4'h0, Base + 32'h04, 32'h0);
        check("CYCLE_HI updated", data_out, 32'h1);

        // Fault capture
        idle();
        dut.ram[1] = 32'h1234_5678;
        drive(1'b1, 4'h0, 32'h0002_0000, 32'h0);
        check("miss load data", data_out, 32'h0);
        check("fault before edge", {31'h0, fault}, 32'h0);
        drive(1'b1, 4'h0, Base + 32'h0C, 32'h0);
        check("fault set", {31'h0, fault}, 32'h1);
        check("FAULT_ADDR", data_out, 32'h0002_0000);
        drive(1'b0, 4'hF, 32'h0003_0004, 32'hCAFE_F00D);
        drive(1'b1, 4'h0, Base + 32'h0C, 32'h0);
        check("FAULT_ADDR kept", data_out, 32'h0002_0000);
        drive(1'b1, 4'h0, 32'h4, 32'h0);
        check("miss store dropped", data_out, 32'h1234_5678);
        drive(1'b1, 4'hF, Base + 32'h20, 32'hFFFF_FFFF);
        check("unmapped read", data_out, 32'h0);
        drive(1'b0, 4'hF, Base, 32'h1234_0000);
        check("done before TOHOST", {31'h0, done}, 32'h0);

        // TOHOST
        drive(1'b0, 4'b0001, Base + 32'h08, 32'hFFFF_FF01);
        check("done before edge", {31'h0, done}, 32'h0);
        drive(1'b1, 4'h0, Base + 32'h08, 32'h0);
        check("done set", {31'h0, done}, 32'h1);
        check("TOHOST value", data_out, 32'h1);
        idle();
        idle();
        check("done sticky", {31'h0, done}, 32'h1);

        // Reset with a concurrent RAM store
        @(negedge clk);
        rst        = 1'b1;
        data_read  = 1'b0;
        data_write = 4'hF;
        data_addr  = 32'h40;
        data_in    = 32'h0;
        #1;
        @(negedge clk);
        rst        = 1'b0;
        data_write = 4'h0;
        data_read  = 1'b1;
        data_addr  = Base;
        #1;
        check("post-rst done", {31'h0, done}, 32'h0);
        check("post-rst fault", {31'h0, fault}, 32'h0);
        check("post-rst CYCLE_LO", data_out, 32'h0);
        drive(1'b1, 4'h0, 32'h40, 32'h0);
        check("RAM kept over rst", data_out, 32'hDEAD_BEEF);

        // Access statistics: 3 RAM loads, 2 RAM stores, 1 miss load since reset
        drive(1'b1, 4'h0, 32'h100, 32'h0);
        drive(1'b1, 4'h0, 32'h4, 32'h0);
        drive(1'b0, 4'hF, 32'h200, 32'h1);
        drive(1'b0, 4'h3, 32'h204, 32'h2);
        drive(1'b1, 4'h0, 32'h0004_0000, 32'h0);
        drive(1'b1, 4'h0, Base + 32'h10, 32'h0);
`ifdef DMEM_ACCESS_STATS_EN
        check("READ_CNT", data_out, 32'd3);
`else
        check("offset 0x10 absent", data_out, 32'd0);
`endif
        drive(1'b1, 4'h0, Base + 32'h14, 32'h0);
`ifdef DMEM_ACCESS_STATS_EN
        check("WRITE_CNT", data_out, 32'd2);
`else
        check("offset 0x14 absent", data_out, 32'd0);
`endif
        drive(1'b1, 4'h0, 32'h200, 32'h0);
        check("stats store word", data_out, 32'h1);
        check("late fault", {31'h0, fault}, 32'h1);

        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
